riscv_reg_dump: RTL and testbench

Debug read-out engine for the RISC-V register file. On a start pulse it walks register addresses 0 to REG_COUNT-1 through one register-file read port, serialises each word into little-endian bytes, and streams them on an 8-bit valid/ready interface. It ends the stream with an XOR checksum byte. It sits beside the core's register file and feeds the debug UART/transport.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/riscv_word_serializer.sv | 49 ++++
 rtl/riscv_reg_dump.sv | 114 +++++++++++
 tb/tb_riscv_reg_dump.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and helpers for the register dump engine.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    CSUM = 2'd3
  } dump_state_t;

  localparam int DUMP_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD  = DUMP_DATA_WIDTH / 8;

  // Byte count of a register word of the given width.
  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/riscv_word_serializer.sv
// Holds one register word and hands it out a byte at a time, LSB first.
module riscv_word_serializer
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  advance,
  output logic [7:0]            byte_out,
  output logic                  last_byte
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  // Load restarts the word; each accepted byte shifts the next one into place.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = word_in;
      idx_d  = '0;
    end else if (advance) begin
      word_d = word_q >> 8;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  // Shift register and byte index.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign byte_out  = word_q[7:0];
  assign last_byte = (idx_q == IDX_W'(BPW - 1));

endmodule

// File: rtl/riscv_reg_dump.sv
// Walks the register file through one read port and streams every word
// LSB first, followed by an XOR checksum byte marked with out_last.
module riscv_reg_dump
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last
);

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            csum_q, csum_d;
  logic                  done_q, done_d;

  logic       ser_load, ser_adv, ser_last;
  logic [7:0] ser_byte;

  riscv_word_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .word_in  (rd_data),
    .advance  (ser_adv),
    .byte_out (ser_byte),
    .last_byte(ser_last)
  );

  // Next state, address walk, checksum and stream outputs. Valid and data
  // depend only on registered state so out_ready never reaches them.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    csum_d    = csum_q;
    done_d    = 1'b0;
    ser_load  = 1'b0;
    ser_adv   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d = '0;
          csum_d    = 8'h00;
          state_d   = READ;
        end
      end
      READ: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = ser_byte;
        if (out_ready) begin
          ser_adv = 1'b1;
          csum_d  = csum_q ^ ser_byte;
          if (ser_last) begin
            if (rd_addr_q == ADDR_WIDTH'(REG_COUNT - 1)) begin
              state_d = CSUM;
            end else begin
              rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
              state_d   = READ;
            end
          end
        end
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_last  = 1'b1;
        if (out_ready) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          rd_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address, checksum and done flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      csum_q    <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      csum_q    <= csum_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_riscv_reg_dump.sv
// Scoreboard bench for riscv_reg_dump: expected bytes are queued when a dump
// is requested and a negedge monitor pops them on every handshake.
module tb_riscv_reg_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  out_data;

  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];
  logic [8:0]  exp_q  [$];
  logic [7:0]  got    [0:255];

  int   total = 0;
  int   bad   = 0;
  int   byte_cnt = 0;
  int   done_cnt = 0;
  logic [7:0] last_csum = 8'h00;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  riscv_reg_dump #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Queue one full dump of exp_rf: 128 data bytes then the checksum.
  task automatic push_dump();
    logic [7:0] cs;
    cs = 8'h00;
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back({1'b0, exp_rf[r][8*b +: 8]});
        cs ^= exp_rf[r][8*b +: 8];
      end
    exp_q.push_back({1'b1, cs});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_addr(input string name, input logic [4:0] a, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && rd_addr == a) && n < budget);
    if (!(out_valid && rd_addr == a)) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Sink ready: held high or a fresh coin toss each cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: stall stability, scoreboard pop on handshake, done timing.
  initial begin
    bit         prev_stall, csum_hs_prev;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;
    prev_stall = 1'b0; csum_hs_prev = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall   = 1'b0;
        csum_hs_prev = 1'b0;
      end else begin
        if (done || csum_hs_prev) chk("done_pulse", {31'd0, done}, {31'd0, csum_hs_prev});
        if (done) done_cnt++;
        if (prev_stall) begin
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
          chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
        end
        if (out_valid && out_ready) begin
          if (byte_cnt < 256) got[byte_cnt] = out_data;
          byte_cnt++;
          if (out_last) last_csum = out_data;
          if (exp_q.size() == 0) begin
            chk("extra_byte", {23'd0, out_last, out_data}, 32'h1ff);
          end else begin
            e = exp_q.pop_front();
            chk("stream_byte", {23'd0, out_last, out_data}, {23'd0, e});
          end
        end
        prev_stall   = out_valid && !out_ready;
        prev_data    = out_data;
        prev_last    = out_last;
        csum_hs_prev = out_valid && out_ready && out_last;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_addr", {27'd0, rd_addr}, 32'd0);

    // Single non-zero register, ready held high, a stray start mid-dump.
    rf[1] = 32'h11223344;
    for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
    push_dump();
    byte_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("t1_read_busy", {31'd0, busy}, 32'd1);
    chk("t1_read_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_first_valid", {31'd0, out_valid}, 32'd1);
    repeat (47) @(posedge clk);
    pulse_start();
    wait_done("t1", 400);
    chk("t1_bytes", byte_cnt, 32'd129);
    chk("t1_b4", {24'd0, got[4]}, 32'h44);
    chk("t1_b5", {24'd0, got[5]}, 32'h33);
    chk("t1_b6", {24'd0, got[6]}, 32'h22);
    chk("t1_b7", {24'd0, got[7]}, 32'h11);
    chk("t1_csum", {24'd0, last_csum}, 32'h44);
    repeat (5) @(negedge clk);
    chk("t1_no_second", {31'd0, busy}, 32'd0);

    // Patterned registers with a randomly stalling sink.
    for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * i;
    for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
    push_dump();
    byte_cnt = 0;
    rand_ready = 1'b1;
    pulse_start();
    wait_done("t2", 2000);
    chk("t2_bytes", byte_cnt, 32'd129);
    chk("t2_b127", {24'd0, got[127]}, 32'h1f);
    rand_ready = 1'b0;

    // Reset while register 7 is streaming, then a clean dump.
    push_dump();
    byte_cnt = 0;
    pulse_start();
    wait_addr("t3", 5'd7, 400);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_addr", {27'd0, rd_addr}, 32'd0);
    push_dump();
    byte_cnt = 0;
    pulse_start();
    wait_done("t3b", 400);
    chk("t3_bytes", byte_cnt, 32'd129);

    // Write to x5 while register 3 streams: new value is dumped.
    exp_rf[5] = 32'hDEADBEEF;
    push_dump();
    byte_cnt = 0;
    pulse_start();
    wait_addr("t4a", 5'd3, 400);
    rf[5] = 32'hDEADBEEF;
    wait_done("t4a", 400);
    chk("t4a_x5", {got[23], got[22], got[21], got[20]}, 32'hDEADBEEF);

    // Same write while register 6 streams: old value is dumped.
    rf[5] = 32'h05050505;
    exp_rf[5] = 32'h05050505;
    push_dump();
    byte_cnt = 0;
    pulse_start();
    wait_addr("t4b", 5'd6, 400);
    rf[5] = 32'hDEADBEEF;
    wait_done("t4b", 400);
    chk("t4b_x5", {got[23], got[22], got[21], got[20]}, 32'h05050505);

    // start held high: back-to-back dumps, second READ right after done.
    for (int i = 0; i < 32; i++) exp_rf[i] = rf[i];
    push_dump();
    push_dump();
    byte_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    wait_done("t5a", 400);
    chk("t5_done_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t5_read_busy", {31'd0, busy}, 32'd1);
    chk("t5_read_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_read_addr", {27'd0, rd_addr}, 32'd0);
    @(posedge clk); #1 start = 1'b0;
    wait_done("t5b", 400);
    chk("t5_bytes", byte_cnt, 32'd258);
    repeat (4) @(negedge clk);
    chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_done_cnt", done_cnt, 32'd2);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
